// File: rtl/ghost_wall_probe_pkg.sv
// Shared maze constants, probe FSM encoding and tile-address helper for the
// ghost and Pac-Man blocks.
package ghost_wall_probe_pkg;

  localparam int MAZE_W     = 28;
  localparam int MAZE_H     = 36;
  localparam int TUNNEL_ROW = 17;
  localparam int ADDR_W     = 10;
  localparam int COORD_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_UP    = 3'd1,
    ST_RD_DOWN  = 3'd2,
    ST_RD_LEFT  = 3'd3,
    ST_RD_RIGHT = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_DONE     = 3'd6
  } probe_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // y*28 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] ty,
                                                  input logic [COORD_W-1:0] tx);
    logic [ADDR_W-1:0] y10;
    logic [ADDR_W-1:0] x10;
    y10 = {{(ADDR_W-COORD_W){1'b0}}, ty};
    x10 = {{(ADDR_W-COORD_W){1'b0}}, tx};
    return (y10 << 4) + (y10 << 3) + (y10 << 2) + x10;
  endfunction

endpackage

// File: rtl/tile_neighbor_addr.sv
// Neighbour tile address for one direction, with maze bounds and the
// horizontal wrap on the tunnel row.
module tile_neighbor_addr #(
  parameter int MAZE_W     = ghost_wall_probe_pkg::MAZE_W,
  parameter int MAZE_H     = ghost_wall_probe_pkg::MAZE_H,
  parameter int TUNNEL_ROW = ghost_wall_probe_pkg::TUNNEL_ROW
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic [1:0] dir,
  output logic [9:0] addr,
  output logic       oob
);
  import ghost_wall_probe_pkg::*;

  localparam logic signed [7:0] W_S = 8'(MAZE_W);
  localparam logic signed [7:0] H_S = 8'(MAZE_H);
  localparam logic signed [7:0] T_S = 8'(TUNNEL_ROW);

  logic signed [7:0] nx;
  logic signed [7:0] ny;

  always_comb begin
    nx  = signed'({2'b00, x});
    ny  = signed'({2'b00, y});
    oob = 1'b0;
    case (dir_e'(dir))
      DIR_UP:    ny = ny - 8'sd1;
      DIR_DOWN:  ny = ny + 8'sd1;
      DIR_LEFT:  nx = nx - 8'sd1;
      DIR_RIGHT: nx = nx + 8'sd1;
      default:   ;
    endcase
    if (ny < 8'sd0 || ny >= H_S) begin
      oob = 1'b1;
    end else if (nx < 8'sd0 || nx >= W_S) begin
      // Only the tunnel row wraps; every other row treats the edge as wall.
      if (ny == T_S) nx = (nx < 8'sd0) ? (W_S - 8'sd1) : 8'sd0;
      else           oob = 1'b1;
    end
    addr = oob ? '0 : tile_addr(ny[5:0], nx[5:0]);
  end

endmodule

// File: rtl/ghost_wall_probe.sv
// Per-frame probe of the four tiles around a ghost against the external maze
// ROM; publishes all four wall flags together with a walls_valid pulse.
module ghost_wall_probe #(
  parameter int MAZE_W     = ghost_wall_probe_pkg::MAZE_W,
  parameter int MAZE_H     = ghost_wall_probe_pkg::MAZE_H,
  parameter int TUNNEL_ROW = ghost_wall_probe_pkg::TUNNEL_ROW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [5:0] ghostX,
  input  logic [5:0] ghostY,
  output logic       mem_rd,
  output logic [9:0] mem_addr,
  input  logic       mem_wall,
  output logic       wallUp,
  output logic       wallDown,
  output logic       wallLeft,
  output logic       wallRight,
  output logic       walls_valid,
  output logic       busy,
  output logic [2:0] dbg_state_o
);
  import ghost_wall_probe_pkg::*;

  probe_state_e state_q, state_d;
  logic [5:0]   x_q, y_q;
  logic [3:0]   shadow_q;
  logic [3:0]   flags_q;
  logic         rd_q;
  logic [1:0]   dir_q;
  logic [1:0]   cur_dir;
  logic         rd_state;
  logic [9:0]   nb_addr;
  logic         nb_oob;

  tile_neighbor_addr #(
    .MAZE_W     (MAZE_W),
    .MAZE_H     (MAZE_H),
    .TUNNEL_ROW (TUNNEL_ROW)
  ) u_nb (
    .x    (x_q),
    .y    (y_q),
    .dir  (cur_dir),
    .addr (nb_addr),
    .oob  (nb_oob)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Ticks outside IDLE (including the DONE cycle) are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (frame_tick) state_d = ST_RD_UP;
      ST_RD_UP:    state_d = ST_RD_DOWN;
      ST_RD_DOWN:  state_d = ST_RD_LEFT;
      ST_RD_LEFT:  state_d = ST_RD_RIGHT;
      ST_RD_RIGHT: state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_dir  = DIR_UP;
    rd_state = 1'b0;
    case (state_q)
      ST_RD_UP:    begin rd_state = 1'b1; cur_dir = DIR_UP;    end
      ST_RD_DOWN:  begin rd_state = 1'b1; cur_dir = DIR_DOWN;  end
      ST_RD_LEFT:  begin rd_state = 1'b1; cur_dir = DIR_LEFT;  end
      ST_RD_RIGHT: begin rd_state = 1'b1; cur_dir = DIR_RIGHT; end
      default:     ;
    endcase
  end

  always_comb begin
    mem_rd      = rd_state && !nb_oob;
    mem_addr    = (rd_state && !nb_oob) ? nb_addr : '0;
    busy        = (state_q != ST_IDLE);
    walls_valid = (state_q == ST_DONE);
  end

  // rd_q/dir_q remember which flag the ROM answer arriving this cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      rd_q     <= 1'b0;
      dir_q    <= DIR_UP;
      shadow_q <= 4'hF;
      flags_q  <= 4'hF;
    end else begin
      if (state_q == ST_IDLE && frame_tick) begin
        x_q <= ghostX;
        y_q <= ghostY;
      end
      rd_q  <= mem_rd;
      dir_q <= cur_dir;
      if (rd_q)               shadow_q[dir_q]   <= mem_wall;
      if (rd_state && nb_oob) shadow_q[cur_dir] <= 1'b1;
      if (state_q == ST_DONE) flags_q <= shadow_q;
    end
  end

  assign wallUp      = flags_q[DIR_UP];
  assign wallDown    = flags_q[DIR_DOWN];
  assign wallLeft    = flags_q[DIR_LEFT];
  assign wallRight   = flags_q[DIR_RIGHT];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ghost_wall_probe.sv
// Directed bench for ghost_wall_probe with a one-cycle-latency maze ROM model.
module tb_ghost_wall_probe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [5:0] ghostX, ghostY;
  logic       mem_rd;
  logic [9:0] mem_addr;
  logic       mem_wall = 1'b0;
  logic       wallUp, wallDown, wallLeft, wallRight;
  logic       walls_valid, busy;
  logic [2:0] dbg_state;
  logic [3:0] flags_obs;

  logic rom [0:1023];

  int tests_run    = 0;
  int tests_failed = 0;

  ghost_wall_probe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .ghostX      (ghostX),
    .ghostY      (ghostY),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_wall    (mem_wall),
    .wallUp      (wallUp),
    .wallDown    (wallDown),
    .wallLeft    (wallLeft),
    .wallRight   (wallRight),
    .walls_valid (walls_valid),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  assign flags_obs = {wallRight, wallLeft, wallDown, wallUp};

  always @(posedge clk) mem_wall <= mem_rd ? rom[mem_addr] : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // exp_addr packs {right,left,down,up}; flag vectors are {R,L,D,U}.
  task automatic probe(input string tag, input logic [5:0] gx, input logic [5:0] gy,
                       input logic [3:0] exp_rd, input logic [39:0] exp_addr,
                       input logic [3:0] prev_flags, input logic [3:0] exp_flags,
                       input logic [5:0] tick_mask, input bit b2b);
    if (!b2b) @(negedge clk);
    ghostX = gx;
    ghostY = gy;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int s = 0; s < 6; s++) begin
      check({tag, "_state"}, 32'(dbg_state), 32'(s + 1));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_flags_hold"}, 32'(flags_obs), 32'(prev_flags));
      check({tag, "_valid"}, 32'(walls_valid), 32'(s == 5));
      if (s < 4) begin
        check({tag, "_rd"}, 32'(mem_rd), 32'(exp_rd[s]));
        if (exp_rd[s]) check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr[s*10 +: 10]));
      end else begin
        check({tag, "_rd_idle"}, 32'(mem_rd), 32'd0);
      end
      frame_tick = tick_mask[s];
      ghostX = 6'd1;
      ghostY = 6'd1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    check({tag, "_end_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_valid"}, 32'(walls_valid), 32'd0);
    check({tag, "_flags"}, 32'(flags_obs), 32'(exp_flags));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 1'b0;
    rom[489]  = 1'b1;
    rom[518]  = 1'b1;
    rom[503]  = 1'b1;
    rom[33]   = 1'b1;
    rom[1006] = 1'b1;
    rom[476]  = 1'b1;
    frame_tick = 1'b0;
    ghostX = 6'd0;
    ghostY = 6'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_flags", 32'(flags_obs), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(walls_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Centre tile; tick during DONE must be dropped.
    probe("centre", 6'd13, 6'd18, 4'b1111, {10'd518, 10'd516, 10'd545, 10'd489},
          4'b1111, 4'b1001, 6'b100000, 1'b0);
    // Tunnel left wrap; tick mid-probe must be dropped.
    probe("tunnel_l", 6'd0, 6'd17, 4'b1111, {10'd477, 10'd503, 10'd504, 10'd448},
          4'b1001, 4'b0100, 6'b000010, 1'b0);
    // Top edge: up neighbour out of bounds.
    probe("top_edge", 6'd5, 6'd0, 4'b1110, {10'd6, 10'd4, 10'd33, 10'd0},
          4'b0100, 4'b0011, 6'b000000, 1'b0);
    // Bottom-right corner off the tunnel row.
    probe("corner", 6'd27, 6'd35, 4'b0101, {10'd0, 10'd1006, 10'd0, 10'd979},
          4'b0011, 4'b1110, 6'b000000, 1'b0);
    // Back-to-back tick in the first IDLE cycle; tunnel right wrap.
    probe("tunnel_r", 6'd27, 6'd17, 4'b1111, {10'd476, 10'd502, 10'd531, 10'd475},
          4'b1110, 4'b1000, 6'b000000, 1'b1);

    // Reset during a probe aborts it.
    @(negedge clk);
    ghostX = 6'd13;
    ghostY = 6'd18;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_flags", 32'(flags_obs), 32'hF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd", 32'(mem_rd), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("abort_valid", 32'(walls_valid), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_abort_valid", 32'(walls_valid), 32'd0);
      check("post_abort_flags", 32'(flags_obs), 32'hF);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    probe("after_abort", 6'd13, 6'd18, 4'b1111, {10'd518, 10'd516, 10'd545, 10'd489},
          4'b1111, 4'b1001, 6'b000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
